// File: rtl/imem_responder.sv
// Instruction-memory responder: accepts PC fetches over valid/ready and
// returns the addressed instruction word, in order, after LATENCY cycles.
// A response FIFO of depth LATENCY+1 absorbs decode backpressure; flush
// drops everything in flight, and a side port preloads the program.
module imem_responder #(
  parameter int          DEPTH     = 1024,
  parameter int          LATENCY   = 2,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_instr,
  output logic [31:0] rsp_addr,
  output logic [1:0]  rsp_err,
  input  logic        flush,
  input  logic        ld_we,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int FD = LATENCY + 1;       // response FIFO depth
  localparam int PW = $clog2(FD);        // FD >= 2, so PW >= 1
  localparam int CW = $clog2(FD + 1);    // holds 0..FD inclusive

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  err;
    logic [31:0] instr;
  } rsp_t;

  logic [31:0] mem [DEPTH];
  rsp_t        fifo_q [FD];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] fifo_cnt, occ;
  rsp_t        new_ent, enq_ent, head;
  logic        acc, deq, enq;
  logic        unused_ld_lsb;

  assign unused_ld_lsb = ^ld_addr[1:0];

  // Preload port: in-range word writes only; non-blocking gives read-before-write.
  // NOTE: storage arrays carry no reset; only the control state that says
  // whether an entry is meaningful is cleared, so rst leaves contents intact.
  always_ff @(posedge clk) begin
    if (ld_we && (ld_addr[31:2] < 30'(DEPTH)))
      mem[ld_addr[AW+1:2]] <= ld_data;
  end

  // Build the response for the current request: error flags, NOP on error.
  always_comb begin
    new_ent       = '0;
    new_ent.addr  = req_addr;
    new_ent.err   = {(req_addr[31:2] >= 30'(DEPTH)), (req_addr[1:0] != 2'b00)};
    new_ent.instr = (new_ent.err != 2'b00) ? NOP_INSTR : mem[req_addr[AW+1:2]];
  end

  // Handshakes; occupancy is judged after this cycle's dequeue so a full
  // buffer that is draining can still take a request.
  assign rsp_valid = (fifo_cnt != '0);
  assign deq       = rsp_valid & rsp_ready;
  assign req_ready = !rst && !flush && ((occ - CW'(deq)) < CW'(FD));
  assign acc       = req_valid & req_ready;

  generate
    if (LATENCY == 1) begin : g_direct
      assign enq     = acc;
      assign enq_ent = new_ent;
    end else begin : g_pipe
      rsp_t               pipe_q [LATENCY-1];
      logic [LATENCY-2:0] pipe_v;

      // Stage valids: shift toward the FIFO, dropped on rst or flush.
      // NOTE: sequential state uses non-blocking assignments so every stage
      // samples the previous stage's value from before the edge.
      always_ff @(posedge clk) begin
        if (rst || flush) begin
          pipe_v <= '0;
        end else begin
          pipe_v[0] <= acc;
          for (int i = 1; i < LATENCY - 1; i++) pipe_v[i] <= pipe_v[i-1];
        end
      end

      // Stage payloads: move unconditionally, qualified by pipe_v.
      always_ff @(posedge clk) begin
        pipe_q[0] <= new_ent;
        for (int i = 1; i < LATENCY - 1; i++) pipe_q[i] <= pipe_q[i-1];
      end

      assign enq     = pipe_v[LATENCY-2];
      assign enq_ent = pipe_q[LATENCY-2];
    end
  endgenerate

  // FIFO pointers, FIFO count and total occupancy; cleared on rst or flush.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fifo_cnt <= '0;
      occ      <= '0;
    end else begin
      if (enq) wr_ptr <= (wr_ptr == PW'(FD - 1)) ? '0 : wr_ptr + 1'b1;
      if (deq) rd_ptr <= (rd_ptr == PW'(FD - 1)) ? '0 : rd_ptr + 1'b1;
      fifo_cnt <= fifo_cnt + CW'(enq) - CW'(deq);
      occ      <= occ + CW'(acc) - CW'(deq);
    end
  end

  // FIFO storage write at the tail.
  always_ff @(posedge clk) begin
    if (enq) fifo_q[wr_ptr] <= enq_ent;
  end

  // Head of FIFO drives the response; fields read zero when nothing is valid.
  always_comb begin
    head      = fifo_q[rd_ptr];
    rsp_instr = '0;
    rsp_addr  = '0;
    rsp_err   = '0;
    if (rsp_valid) begin
      rsp_instr = head.instr;
      rsp_addr  = head.addr;
      rsp_err   = head.err;
    end
  end

endmodule
